// File: rtl/addsub_arbiter.sv
// addsub_arbiter: round-robin sharing of one combinational add/sub unit between two valid/ready requesters.
// Define FIXED_PRIO_EN to make requester 0 always win a tie.
module addsub_arbiter #(
    parameter int DATA_W = 4
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              req0_valid,
    output logic              req0_ready,
    input  logic [DATA_W-1:0] req0_a,
    input  logic [DATA_W-1:0] req0_b,
    input  logic              req0_m,
    input  logic              req1_valid,
    output logic              req1_ready,
    input  logic [DATA_W-1:0] req1_a,
    input  logic [DATA_W-1:0] req1_b,
    input  logic              req1_m,
    output logic [DATA_W-1:0] au_a,
    output logic [DATA_W-1:0] au_b,
    output logic              au_m,
    input  logic [DATA_W-1:0] au_s,
    input  logic              au_v,
    output logic              rsp_valid,
    input  logic              rsp_ready,
    output logic              rsp_id,
    output logic [DATA_W-1:0] rsp_s,
    output logic              rsp_v
);
    localparam logic [1:0] IDLE = 2'd0;
    localparam logic [1:0] EXEC = 2'd1;
    localparam logic [1:0] RESP = 2'd2;

    logic [1:0]        state_q, state_d;
    logic              last_q, last_d;
    logic              id_q, id_d;
    logic [DATA_W-1:0] a_q, a_d, b_q, b_d, s_q, s_d;
    logic              m_q, m_d, v_q, v_d;
    logic              pick1;

`ifdef FIXED_PRIO_EN
    logic unused_last;
    assign unused_last = last_q;
    assign pick1 = req1_valid && !req0_valid;
`else
    // On a tie the requester that did not win last time gets the unit.
    assign pick1 = req1_valid && (!req0_valid || !last_q);
`endif

    assign req0_ready = (state_q == IDLE) && req0_valid && !pick1;
    assign req1_ready = (state_q == IDLE) && pick1;
    assign au_a       = a_q;
    assign au_b       = b_q;
    assign au_m       = m_q;
    assign rsp_valid  = (state_q == RESP);
    assign rsp_id     = id_q;
    assign rsp_s      = s_q;
    assign rsp_v      = v_q;

    always_comb begin
        state_d = state_q;
        last_d  = last_q;
        id_d    = id_q;
        a_d     = a_q;
        b_d     = b_q;
        m_d     = m_q;
        s_d     = s_q;
        v_d     = v_q;
        if (req0_ready || req1_ready) begin
            a_d     = req1_ready ? req1_a : req0_a;
            b_d     = req1_ready ? req1_b : req0_b;
            m_d     = req1_ready ? req1_m : req0_m;
            id_d    = req1_ready;
            last_d  = req1_ready;
            state_d = EXEC;
        end
        if (state_q == EXEC) begin
            s_d     = au_s;
            v_d     = au_v;
            state_d = RESP;
        end
        if (state_q == RESP && rsp_ready) state_d = IDLE;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= IDLE;
            last_q  <= 1'b1;
            id_q    <= 1'b0;
            a_q     <= '0;
            b_q     <= '0;
            m_q     <= 1'b0;
            s_q     <= '0;
            v_q     <= 1'b0;
        end else begin
            state_q <= state_d;
            last_q  <= last_d;
            id_q    <= id_d;
            a_q     <= a_d;
            b_q     <= b_d;
            m_q     <= m_d;
            s_q     <= s_d;
            v_q     <= v_d;
        end
    end
endmodule

// File: tb/tb_addsub_arbiter.sv
// tb_addsub_arbiter: table-driven and randomized checks of addsub_arbiter with a stand-in add/sub unit.
module tb_addsub_arbiter;
`ifdef FIXED_PRIO_EN
    localparam bit FIXED = 1'b1;
`else
    localparam bit FIXED = 1'b0;
`endif

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic       req0_valid = 1'b0, req1_valid = 1'b0, req0_m = 1'b0, req1_m = 1'b0;
    logic [3:0] req0_a = '0, req0_b = '0, req1_a = '0, req1_b = '0;
    logic       req0_ready, req1_ready, au_m, au_v, rsp_valid, rsp_id, rsp_v;
    logic       rsp_ready = 1'b0;
    logic [3:0] au_a, au_b, au_s, rsp_s, bb;
    int         vec_n = 0, miss_n = 0;
    bit         model_last;

    typedef struct {
        bit         v0; logic [3:0] a0, b0; bit m0;
        bit         v1; logic [3:0] a1, b1; bit m1;
        int         eid; logic [3:0] es; bit ev; int hold;
    } vec_t;

    vec_t tbl[6];

    always #5 clk = ~clk;

    // Stand-in unit: two's complement add/sub, overflow when operand signs agree but the result's differs.
    assign bb   = au_m ? ~au_b : au_b;
    assign au_s = au_m ? au_a - au_b : au_a + au_b;
    assign au_v = (au_a[3] == bb[3]) && (au_s[3] != au_a[3]);

    addsub_arbiter #(.DATA_W(4)) dut (
        .clk(clk), .rst_n(rst_n),
        .req0_valid(req0_valid), .req0_ready(req0_ready), .req0_a(req0_a), .req0_b(req0_b), .req0_m(req0_m),
        .req1_valid(req1_valid), .req1_ready(req1_ready), .req1_a(req1_a), .req1_b(req1_b), .req1_m(req1_m),
        .au_a(au_a), .au_b(au_b), .au_m(au_m), .au_s(au_s), .au_v(au_v),
        .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_id(rsp_id), .rsp_s(rsp_s), .rsp_v(rsp_v)
    );

    task automatic chk(input string n, input int got, input int exp);
        vec_n++;
        if (got != exp) begin
            miss_n++;
            $display("FAIL %s got=%0d expected=%0d at %0t", n, got, exp, $time);
        end
    endtask

    task automatic model(input bit m, input logic [3:0] a, input logic [3:0] b,
                         output logic [3:0] s, output bit v);
        int sa, sb, r;
        sa = $signed(a);
        sb = $signed(b);
        r  = m ? sa - sb : sa + sb;
        s  = r[3:0];
        v  = (r > 7) || (r < -8);
    endtask

    task automatic build(input bit v0, input logic [3:0] a0, input logic [3:0] b0, input bit m0,
                         input bit v1, input logic [3:0] a1, input logic [3:0] b1, input bit m1,
                         input int hold, output vec_t t);
        int id;
        id = (v0 && v1) ? (FIXED ? 0 : int'(!model_last)) : int'(v1);
        model_last = id[0];
        t.v0 = v0; t.a0 = a0; t.b0 = b0; t.m0 = m0;
        t.v1 = v1; t.a1 = a1; t.b1 = b1; t.m1 = m1;
        t.eid = id; t.hold = hold;
        if (id == 1) model(m1, a1, b1, t.es, t.ev);
        else         model(m0, a0, b0, t.es, t.ev);
    endtask

    task automatic txn(input vec_t t);
        int w;
        @(negedge clk);
        req0_valid = t.v0; req0_a = t.a0; req0_b = t.b0; req0_m = t.m0;
        req1_valid = t.v1; req1_a = t.a1; req1_b = t.b1; req1_m = t.m1;
        rsp_ready = 1'b0;
        #1;
        w = 0;
        while (!(req0_ready || req1_ready) && w < 10) begin
            @(negedge clk); #1; w++;
        end
        if (w == 10) begin
            chk("grant_timeout", 0, 1);
            req0_valid = 1'b0; req1_valid = 1'b0;
            return;
        end
        chk("grant_id", int'(req1_ready), t.eid);
        chk("single_ready", int'(req0_ready && req1_ready), 0);
        @(posedge clk); #1;
        req0_valid = 1'b0; req1_valid = 1'b0;
        chk("exec_rsp_valid", int'(rsp_valid), 0);
        @(posedge clk); #1;
        chk("rsp_valid", int'(rsp_valid), 1);
        chk("rsp_id", int'(rsp_id), t.eid);
        chk("rsp_s", int'(rsp_s), int'(t.es));
        chk("rsp_v", int'(rsp_v), int'(t.ev));
        for (int i = 0; i < t.hold; i++) begin
            req0_valid = 1'b1; req1_valid = 1'b1;
            @(posedge clk); #1;
            chk("hold_ready0", int'(req0_ready), 0);
            chk("hold_ready1", int'(req1_ready), 0);
            chk("hold_valid", int'(rsp_valid), 1);
            chk("hold_s", int'(rsp_s), int'(t.es));
            chk("hold_id", int'(rsp_id), t.eid);
        end
        req0_valid = 1'b0; req1_valid = 1'b0; rsp_ready = 1'b1;
        @(posedge clk); #1;
        rsp_ready = 1'b0;
        chk("rsp_drop", int'(rsp_valid), 0);
    endtask

    task automatic do_reset();
        @(negedge clk);
        rst_n = 1'b0;
        req0_valid = 1'b0; req1_valid = 1'b0; rsp_ready = 1'b0;
        #1;
        chk("rst_rsp_valid", int'(rsp_valid), 0);
        chk("rst_au_a", int'(au_a), 0);
        chk("rst_au_b", int'(au_b), 0);
        chk("rst_au_m", int'(au_m), 0);
        chk("rst_rsp_s", int'(rsp_s), 0);
        chk("rst_rsp_v", int'(rsp_v), 0);
        chk("rst_rsp_id", int'(rsp_id), 0);
        repeat (2) @(posedge clk);
        @(negedge clk);
        rst_n = 1'b1;
        model_last = 1'b1;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog expired");
        $fatal(1, "watchdog");
    end

    initial begin
        vec_t t;
        tbl[0] = '{1'b1, 4'h3, 4'h4, 1'b0, 1'b0, 4'h0, 4'h0, 1'b0, 0, 4'h7, 1'b0, 0};
        tbl[1] = '{1'b0, 4'h0, 4'h0, 1'b0, 1'b1, 4'h3, 4'h4, 1'b1, 1, 4'hF, 1'b0, 0};
        tbl[2] = '{1'b1, 4'hC, 4'h5, 1'b1, 1'b1, 4'h4, 4'hC, 1'b1, 0, 4'h7, 1'b1, 0};
        tbl[3] = FIXED ? '{1'b1, 4'hC, 4'h5, 1'b1, 1'b1, 4'h4, 4'hC, 1'b1, 0, 4'h7, 1'b1, 0}
                       : '{1'b1, 4'hC, 4'h5, 1'b1, 1'b1, 4'h4, 4'hC, 1'b1, 1, 4'h8, 1'b1, 0};
        tbl[4] = '{1'b1, 4'hC, 4'h5, 1'b1, 1'b1, 4'h4, 4'hC, 1'b1, 0, 4'h7, 1'b1, 0};
        tbl[5] = FIXED ? '{1'b1, 4'hC, 4'h5, 1'b1, 1'b1, 4'h4, 4'hC, 1'b1, 0, 4'h7, 1'b1, 5}
                       : '{1'b1, 4'hC, 4'h5, 1'b1, 1'b1, 4'h4, 4'hC, 1'b1, 1, 4'h8, 1'b1, 5};

        do_reset();
        @(negedge clk); #1;
        chk("idle_ready0", int'(req0_ready), 0);
        chk("idle_ready1", int'(req1_ready), 0);
        for (int i = 0; i < 6; i++) txn(tbl[i]);

        // Reset during EXEC discards the op and restores req0's tie priority.
        @(negedge clk);
        req0_valid = 1'b1; req0_a = 4'hC; req0_b = 4'h4; req0_m = 1'b0;
        #1;
        chk("r5_ready0", int'(req0_ready), 1);
        @(posedge clk); #1;
        req0_valid = 1'b0;
        chk("r5_au_a", int'(au_a), 12);
        chk("r5_au_b", int'(au_b), 4);
        @(negedge clk);
        rst_n = 1'b0;
        #1;
        chk("r5_rsp_valid", int'(rsp_valid), 0);
        chk("r5_au_a_clr", int'(au_a), 0);
        chk("r5_rsp_s", int'(rsp_s), 0);
        @(negedge clk);
        rst_n = 1'b1;
        for (int i = 0; i < 3; i++) begin
            @(negedge clk); #1;
            chk("r5_no_rsp", int'(rsp_valid), 0);
        end
        model_last = 1'b1;
        for (int i = 0; i < 4; i++) begin
            build(1'b1, 4'hC, 4'h5, 1'b1, 1'b1, 4'h4, 4'hC, 1'b1, 0, t);
            txn(t);
        end

        do_reset();
        for (int i = 0; i < 150; i++) begin
            bit v0, v1;
            v0 = 1'($urandom);
            v1 = 1'($urandom);
            if (!v0 && !v1) begin
                @(negedge clk); #1;
                chk("rand_idle_ready", int'(req0_ready || req1_ready), 0);
                continue;
            end
            build(v0, 4'($urandom), 4'($urandom), 1'($urandom),
                  v1, 4'($urandom), 4'($urandom), 1'($urandom), int'($urandom_range(0, 2)), t);
            txn(t);
        end

        $display("== %0d vectors applied, %0d miscompares ==", vec_n, miss_n);
        $finish;
    end
endmodule
